// File: rtl/shift_rotate_if.sv
// Request/result handshake bundle for shift_rotate_unit.
// The unit connects through the slave modport; the requester uses master.
interface shift_rotate_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [AMT_W-1:0] in_amt;
  logic [2:0]       in_op;
  logic             in_carry;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_carry;
  logic             out_zero;

  modport master (
    output in_valid, in_data, in_amt, in_op, in_carry, out_ready,
    input  in_ready, out_valid, out_data, out_carry, out_zero
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_op, in_carry, out_ready,
    output in_ready, out_valid, out_data, out_carry, out_zero
  );
endinterface

// File: rtl/shift_rotate_unit.sv
// Shift/rotate unit: iterative 1-bit-per-cycle engine by default; defining
// SHIFT_ROTATE_FAST_EN computes the whole result on accept (latency 1).
//
// state | meaning
// IDLE  | waiting for a request (in_ready high)
// BUSY  | stepping the latched operand one bit per cycle
// DONE  | result presented (out_valid high) until out_ready
module shift_rotate_unit #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input logic          clk,
  input logic          rst_n,
  shift_rotate_if.slave bus
);
  localparam logic [2:0] OP_ROR  = 3'd0;
  localparam logic [2:0] OP_ROL  = 3'd1;
  localparam logic [2:0] OP_SHR  = 3'd2;
  localparam logic [2:0] OP_SHL  = 3'd3;
  localparam logic [2:0] OP_SAR  = 3'd4;
  localparam logic [2:0] OP_RCR  = 3'd5;
  localparam logic [2:0] OP_RCL  = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] data_q;
  logic             carry_q;
  logic [2:0]       op_q;
  logic [AMT_W-1:0] rem;
  logic [WIDTH-1:0] out_data_q;
  logic             out_carry_q;
  logic             out_zero_q;

  // Result packed as {carry, data}
  function automatic logic [WIDTH:0] step(input logic [2:0] op,
                                          input logic [WIDTH-1:0] d,
                                          input logic c);
    logic [WIDTH:0] r;
    r = {c, d};
    case (op)
      OP_ROR:  r = {d[0], d[0], d[WIDTH-1:1]};
      OP_ROL:  r = {d[WIDTH-1], d[WIDTH-2:0], d[WIDTH-1]};
      OP_SHR:  r = {d[0], 1'b0, d[WIDTH-1:1]};
      OP_SHL:  r = {d[WIDTH-1], d[WIDTH-2:0], 1'b0};
      OP_SAR:  r = {d[0], d[WIDTH-1], d[WIDTH-1:1]};
      OP_RCR:  r = {d[0], c, d[WIDTH-1:1]};
      OP_RCL:  r = {d[WIDTH-1], d[WIDTH-2:0], c};
      default: r = {c, d};
    endcase
    return r;
  endfunction

  logic [WIDTH:0] acc_res;
  logic           acc_done;
  logic [WIDTH:0] step_res;

`ifdef SHIFT_ROTATE_FAST_EN
  function automatic logic [WIDTH:0] full_result(input logic [2:0] op,
                                                 input logic [WIDTH-1:0] d,
                                                 input logic c,
                                                 input logic [AMT_W-1:0] amt);
    logic [WIDTH:0] r;
    r = {c, d};
    for (int i = 0; i < WIDTH - 1; i++)
      if (i < int'(amt)) r = step(op, r[WIDTH-1:0], r[WIDTH]);
    return r;
  endfunction

  assign acc_res  = full_result(bus.in_op, bus.in_data, bus.in_carry, bus.in_amt);
  assign acc_done = 1'b1;
`else
  // The first step happens on the accept edge so latency equals the amount
  assign acc_res  = step(bus.in_op, bus.in_data, bus.in_carry);
  assign acc_done = (bus.in_amt == AMT_W'(1));
`endif

  assign step_res = step(op_q, data_q, carry_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      data_q      <= '0;
      carry_q     <= 1'b0;
      op_q        <= OP_ROR;
      rem         <= '0;
      out_data_q  <= '0;
      out_carry_q <= 1'b0;
      out_zero_q  <= 1'b1;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          op_q <= bus.in_op;
          if (bus.in_amt == '0 || bus.in_op == OP_PASS) begin
            data_q      <= bus.in_data;
            carry_q     <= bus.in_carry;
            rem         <= '0;
            out_data_q  <= bus.in_data;
            out_carry_q <= bus.in_carry;
            out_zero_q  <= (bus.in_data == '0);
            state       <= DONE;
          end else begin
            data_q  <= acc_res[WIDTH-1:0];
            carry_q <= acc_res[WIDTH];
            rem     <= bus.in_amt - AMT_W'(1);
            if (acc_done) begin
              out_data_q  <= acc_res[WIDTH-1:0];
              out_carry_q <= acc_res[WIDTH];
              out_zero_q  <= (acc_res[WIDTH-1:0] == '0);
              state       <= DONE;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          data_q  <= step_res[WIDTH-1:0];
          carry_q <= step_res[WIDTH];
          rem     <= rem - AMT_W'(1);
          if (rem == AMT_W'(1)) begin
            out_data_q  <= step_res[WIDTH-1:0];
            out_carry_q <= step_res[WIDTH];
            out_zero_q  <= (step_res[WIDTH-1:0] == '0);
            state       <= DONE;
          end
        end
        DONE: if (bus.out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_data  = out_data_q;
  assign bus.out_carry = out_carry_q;
  assign bus.out_zero  = out_zero_q;
endmodule

// File: doc/shift_rotate_unit.md
SHIFT_ROTATE_UNIT -- requirements
Module: shift_rotate_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data width in bits, minimum 2.
REQ-002 SHALL have parameter AMT_W, default 3: shift-amount width, equal to $clog2(WIDTH).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  request valid.
REQ-006 SHALL have port in_ready  output  1  unit can accept a request.
REQ-007 SHALL have port in_data  input  WIDTH  operand.
REQ-008 SHALL have port in_amt  input  AMT_W  shift/rotate count, 0..WIDTH-1.
REQ-009 SHALL have port in_op  input  3  operation select (REQ-013).
REQ-010 SHALL have port in_carry  input  1  carry-in for RCR/RCL.
REQ-011 SHALL have ports out_valid  output  1; out_ready  input  1; out_data  output  WIDTH; out_carry  output  1; out_zero  output  1: result handshake, result, carry-out, zero flag.

Function
REQ-012 SHALL use states IDLE, BUSY, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-013 SHALL decode in_op: 000 ROR, 001 ROL, 010 SHR logical, 011 SHL, 100 SAR, 101 RCR (WIDTH+1-bit rotate through carry), 110 RCL, 111 PASS (data unchanged, carry = in_carry).
REQ-014 SHALL on accept (in_valid & in_ready) latch in_data, in_op, in_carry, and remaining count = in_amt; move to DONE if in_amt==0 or op==PASS, else BUSY.
REQ-015 SHALL in BUSY perform exactly one 1-bit step per cycle on the latched data/carry and decrement remaining; the step with remaining==1 moves to DONE.
REQ-016 SHALL give latency max(in_amt,1) cycles from accept edge to out_valid high; back-to-back throughput one request per latency+1 cycles.
REQ-017 SHALL set out_carry = last bit shifted/rotated out for ROR/ROL/SHR/SHL/SAR; new carry bit for RCR/RCL; latched in_carry when amount is 0.
REQ-018 SHALL fill vacated bits with 0 for SHR/SHL and with the latched MSB for SAR.
REQ-019 SHALL drive out_zero = (out_data == 0), registered with out_data.
REQ-020 SHALL hold out_data/out_carry/out_zero stable in DONE until out_ready high; DONE & out_ready moves to IDLE on that edge.
REQ-021 SHALL ignore in_valid while not IDLE; last output values remain on out_data after leaving DONE.

Reset
REQ-022 SHALL on rst_n low, immediately and regardless of state (including mid-BUSY): state=IDLE, out_data=0, out_carry=0, out_zero=1, remaining=0; in-flight request discarded.
REQ-023 SHALL give in_ready=1 and out_valid=0 from reset; first accept on first rising edge after rst_n deasserts.

Configuration
REQ-024 SHALL, with macro SHIFT_ROTATE_FAST_EN defined, compute the full result combinationally on accept and go directly to DONE (latency 1 for all amounts, BUSY unused); results identical to iterative mode.
REQ-025 SHALL, with SHIFT_ROTATE_FAST_EN undefined, use the iterative 1-bit-per-cycle path of REQ-015.

Verification (WIDTH=8)
REQ-026 SHALL test ROR 0xB1 amt 1 -> out_data 0xD8, out_carry 1, out_zero 0, out_valid 1 cycle after accept.
REQ-027 SHALL test SAR 0x80 amt 3 -> 0xF0, carry 0; iterative latency 3 cycles, fast latency 1.
REQ-028 SHALL test RCL 0x80 in_carry 0 amt 1 -> 0x00, carry 1, zero 1; SHL 0x01 amt 7 -> 0x80, carry 0, latency 7 (iterative).
REQ-029 SHALL test out_ready held low 5 cycles in DONE -> outputs stable, in_ready 0, new in_valid ignored; out_ready high -> IDLE next edge.
REQ-030 SHALL test rst_n pulsed low mid-BUSY of SHL amt 6 -> immediate IDLE, out_data 0x00, out_zero 1, no out_valid; next request completes correctly.
